// File: rtl/apu_pkg.sv
// Shared APU constants and types for the channel 4 register stage.
// Holds the NR4x addresses, length-counter width and FF23 read mask.
package apu_pkg;

  localparam logic [15:0] NR41_ADDR = 16'hFF20;
  localparam logic [15:0] NR42_ADDR = 16'hFF21;
  localparam logic [15:0] NR43_ADDR = 16'hFF22;
  localparam logic [15:0] NR44_ADDR = 16'hFF23;

  localparam int          LEN_W        = 6;
  localparam logic [7:0]  FF23_RD_MASK = 8'hBF;

  // Winner of the length counter's next-state selection, highest priority first.
  typedef enum logic [1:0] {
    WR_LOAD      = 2'd0,
    RESTART_LOAD = 2'd1,
    TICK_INC     = 2'd2,
    HOLD         = 2'd3
  } len_op_e;

endpackage

// File: rtl/ch4_regs_if.sv
// CPU register bus for the channel 4 register block: one-hot selects, strobes, data.
// Handshake: no valid/ready; a write is taken on every dova_phi rising edge where cpu_wr=1, and reads are combinational while ncpu_rd=0.
interface ch4_regs_if;
  import apu_pkg::*;

  logic       cpu_wr;
  logic       ncpu_rd;
  logic       ff20;
  logic       ff21;
  logic       ff22;
  logic       ff23;
  logic [7:0] d_in;
  logic [7:0] d_out;
  logic       d_oe;

  modport master (
    output cpu_wr, ncpu_rd, ff20, ff21, ff22, ff23, d_in,
    input  d_out, d_oe
  );

  modport slave (
    input  cpu_wr, ncpu_rd, ff20, ff21, ff22, ff23, d_in,
    output d_out, d_oe
  );
endinterface

// File: rtl/ch4_length_counter.sv
// Channel 4 length timer: edge-detects the 256 Hz frame clock and counts up
// to the terminal count, raising fugo_q when the length has expired.
module ch4_length_counter
  import apu_pkg::*;
#(
  parameter int LEN_W_P = LEN_W
) (
  input  logic               dova_phi,
  input  logic               apu_reset,
  input  logic               len_256hz,
  input  logic               load,
  input  logic [LEN_W_P-1:0] load_val,
  input  logic               ch4_restart,
  input  logic               ff23_d6,
  output logic               fugo_q,
  output len_op_e            op_dbg
);

  logic               len_q;
  logic               len_prev;
  logic               tick;
  logic [LEN_W_P-1:0] cnt;
  len_op_e            op;

  // len_256hz is registered once before edge detection, so tick lags the input by one cycle.
  assign tick   = len_q & ~len_prev;
  assign op_dbg = op;

  always_comb begin
    op = HOLD;
    if (load)                             op = WR_LOAD;
    else if (ch4_restart && fugo_q)       op = RESTART_LOAD;
    else if (tick && ff23_d6 && !fugo_q)  op = TICK_INC;
  end

  always_ff @(posedge dova_phi or posedge apu_reset) begin
    if (apu_reset) begin
      len_q    <= 1'b0;
      len_prev <= 1'b0;
      cnt      <= '0;
      fugo_q   <= 1'b0;
    end else begin
      len_q    <= len_256hz;
      len_prev <= len_q;
      unique case (op)
        WR_LOAD: begin
          cnt    <= load_val;
          fugo_q <= 1'b0;
        end
        RESTART_LOAD: begin
          cnt    <= '0;
          fugo_q <= 1'b0;
        end
        TICK_INC: begin
          cnt <= cnt + 1'b1;
          if (&cnt) fugo_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ch4_regs.sv
// NR41-NR44 register stage feeding channel 4: register file, CPU read mux,
// self-clearing trigger bit and the length timer.
module ch4_regs
  import apu_pkg::*;
(
  input  logic        dova_phi,
  input  logic        apu_reset,
  ch4_regs_if.slave   bus,
  input  logic        len_256hz,
  input  logic        ch4_restart,
  input  logic        rst_ff23_d7,
  output logic [7:0]  ff21_q,
  output logic [7:0]  nff21_q,
  output logic [7:0]  ff22_q,
  output logic [7:0]  nff22_q,
  output logic        ff23_d6,
  output logic        ff23_d7,
  output logic        fugo_q,
  output len_op_e     len_op_dbg
);

  logic wr20;
  logic wr21;
  logic wr22;
  logic wr23;

  assign wr20 = bus.cpu_wr & bus.ff20;
  assign wr21 = bus.cpu_wr & bus.ff21;
  assign wr22 = bus.cpu_wr & bus.ff22;
  assign wr23 = bus.cpu_wr & bus.ff23;

  assign nff21_q = ~ff21_q;
  assign nff22_q = ~ff22_q;

  always_ff @(posedge dova_phi or posedge apu_reset) begin
    if (apu_reset) begin
      ff21_q  <= 8'h00;
      ff22_q  <= 8'h00;
      ff23_d6 <= 1'b0;
      ff23_d7 <= 1'b0;
    end else begin
      if (wr21) ff21_q <= bus.d_in;
      if (wr22) ff22_q <= bus.d_in;
      // A same-edge retrigger beats channel 4's clear so it is never lost.
      if (wr23) begin
        ff23_d6 <= bus.d_in[6];
        ff23_d7 <= bus.d_in[7];
      end else if (rst_ff23_d7) begin
        ff23_d7 <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.d_oe  = ~bus.ncpu_rd & (bus.ff20 | bus.ff21 | bus.ff22 | bus.ff23);
    bus.d_out = 8'hFF;
    if (bus.ff21)      bus.d_out = ff21_q;
    else if (bus.ff22) bus.d_out = ff22_q;
    else if (bus.ff23) bus.d_out = FF23_RD_MASK | {1'b0, ff23_d6, 6'b0};
  end

  ch4_length_counter #(.LEN_W_P(LEN_W)) u_len (
    .dova_phi    (dova_phi),
    .apu_reset   (apu_reset),
    .len_256hz   (len_256hz),
    .load        (wr20),
    .load_val    (bus.d_in[LEN_W-1:0]),
    .ch4_restart (ch4_restart),
    .ff23_d6     (ff23_d6),
    .fugo_q      (fugo_q),
    .op_dbg      (len_op_dbg)
  );

endmodule
